// File: rtl/vec_stream_tx_64_16.sv
// Vector stream transmitter: an X-entry sample memory streamed out over a
// valid/ready port. A registered read stage feeds a registered output stage.
module vec_stream_tx_64_16 #(
  parameter int X     = 64,
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [$clog2(X)-1:0]    wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] x_data,
  output logic                    x_valid,
  input  logic                    x_ready
);

  localparam int AW = $clog2(X);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    STREAM   = 2'd2,
    FINISH   = 2'd3
  } state_t;

  logic [WIDTH-1:0] mem [X];
  logic [WIDTH-1:0] mem_rdata_q;

  state_t           state_q, state_d;
  logic [CW-1:0]    rd_addr_q, rd_addr_d;
  logic [CW-1:0]    beat_q, beat_d;
  logic             rd_vld_q, rd_vld_d;
  logic [WIDTH-1:0] x_data_q, x_data_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pend_v_q, pend_v_d;
  logic [AW-1:0]    pend_addr_q, pend_addr_d;
  logic [WIDTH-1:0] pend_data_q, pend_data_d;

  logic             hs_s;
  logic             move_s;
  logic             rd_en_s;
  logic             defer_s;
  logic             commit_s;
  logic             mem_we_s;
  logic [AW-1:0]    mem_waddr_s;
  logic [WIDTH-1:0] mem_wdata_s;

  assign busy    = busy_q;
  assign done    = done_q;
  assign x_data  = $signed(x_data_q);
  assign x_valid = x_valid_q;

  // Handshake, stage-advance, read-issue and memory write-port control.
  always_comb begin
    hs_s     = x_valid_q & x_ready;
    move_s   = rd_vld_q & (~x_valid_q | x_ready);
    rd_en_s  = 1'b0;
    if (((state_q == PREFETCH) || (state_q == STREAM)) &&
        (rd_addr_q < CW'(X)) && (~rd_vld_q | move_s)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
    // A write coinciding with start is held back until its address has been read.
    defer_s  = (state_q == IDLE) & start & wr_en;
    commit_s = pend_v_q & (rd_addr_q > {1'b0, pend_addr_q});
    if (commit_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = pend_addr_q;
      mem_wdata_s = pend_data_q;
    end else begin
      mem_we_s    = wr_en & ~busy_q & ~defer_s;
      mem_waddr_s = wr_addr;
      mem_wdata_s = wr_data;
    end
  end

  // Sample memory: synchronous write, registered read; contents are never reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_waddr_s] <= mem_wdata_s;
    end
    if (rd_en_s) begin
      mem_rdata_q <= mem[rd_addr_q[AW-1:0]];
    end
  end

  // FSM next state plus pipeline, counter and pending-write updates.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    beat_d      = beat_q;
    rd_vld_d    = rd_vld_q;
    x_data_d    = x_data_q;
    x_valid_d   = x_valid_q;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = PREFETCH;
          rd_addr_d = {CW{1'b0}};
          beat_d    = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      PREFETCH: state_d = STREAM;
      STREAM: begin
        if (hs_s && (beat_q == CW'(X - 1))) begin
          state_d = FINISH;
        end else begin
          state_d = STREAM;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (rd_en_s) begin
      rd_addr_d = rd_addr_q + CW'(1);
    end else begin
      rd_addr_d = rd_addr_d;
    end
    if (hs_s) begin
      beat_d = beat_q + CW'(1);
    end else begin
      beat_d = beat_d;
    end

    if (rd_en_s) begin
      rd_vld_d = 1'b1;
    end else if (move_s) begin
      rd_vld_d = 1'b0;
    end else begin
      rd_vld_d = rd_vld_q;
    end

    if (move_s) begin
      x_valid_d = 1'b1;
      x_data_d  = mem_rdata_q;
    end else if (hs_s) begin
      x_valid_d = 1'b0;
    end else begin
      x_valid_d = x_valid_q;
    end

    if (defer_s) begin
      pend_v_d    = 1'b1;
      pend_addr_d = wr_addr;
      pend_data_d = wr_data;
    end else if (commit_s) begin
      pend_v_d = 1'b0;
    end else begin
      pend_v_d = pend_v_q;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_addr_q   <= {CW{1'b0}};
      beat_q      <= {CW{1'b0}};
      rd_vld_q    <= 1'b0;
      x_data_q    <= {WIDTH{1'b0}};
      x_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_addr_q <= {AW{1'b0}};
      pend_data_q <= {WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      beat_q      <= beat_d;
      rd_vld_q    <= rd_vld_d;
      x_data_q    <= x_data_d;
      x_valid_q   <= x_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
    end
  end

endmodule

// File: tb/tb_vec_stream_tx_64_16.sv
// Directed self-checking bench for vec_stream_tx_64_16.
module tb_vec_stream_tx_64_16;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [5:0]        wr_addr;
  logic [15:0]       wr_data;
  logic              start;
  logic              busy;
  logic              done;
  logic signed [15:0] x_data;
  logic              x_valid;
  logic              x_ready;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic signed [15:0] rx_q[$];

  vec_stream_tx_64_16 #(.X(64), .WIDTH(16)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .x_data(x_data), .x_valid(x_valid),
    .x_ready(x_ready)
  );

  always #5 clk = ~clk;

  // Record handshakes (values that the next rising edge will sample).
  always @(negedge clk) begin
    if (x_valid && x_ready) rx_q.push_back(x_data);
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 64; i++) begin
      wr_en = 1'b1; wr_addr = 6'(i); wr_data = 16'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Start one vector and wait (bounded) until it has finished.
  task automatic run_vector(output bit ok);
    ok = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (done) begin ok = 1'b1; break; end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; wr_en = 1'b0; wr_addr = 6'd0; wr_data = 16'd0; start = 1'b0; x_ready = 1'b1;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || x_data !== 16'sd0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b busy=%b done=%b data=%0d, want 0 0 0 0",
               x_valid, busy, done, x_data);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    load_ramp();
    x_ready = 1'b1;
    rx_q.delete(); done_cnt = 0;
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (busy !== 1'b1 || x_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_after_start: got busy=%b valid=%b, want 1 0", busy, x_valid);
    end
    tick();
    checks++;
    if (x_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_prefetch_valid: got %b, want 0", x_valid);
    end
    tick();
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (x_valid !== 1'b1 || x_data !== 16'(k)) begin
        failures++;
        $display("FAIL basic_beat%0d: got valid=%b data=%0d, want 1 %0d", k, x_valid, x_data, k);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || x_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_finish: got done=%b busy=%b valid=%b, want 1 1 0", done, busy, x_valid);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle: got done=%b busy=%b, want 0 0", done, busy);
    end
    ok = (rx_q.size() == 64);
    for (int k = 0; k < 64 && ok; k++) if (rx_q[k] !== 16'(k)) ok = 1'b0;
    checks++;
    if (!ok || done_cnt != 1) begin
      failures++;
      $display("FAIL basic_rx: got %0d beats done_cnt=%0d, want ramp of 64 and 1", rx_q.size(), done_cnt);
    end
  endtask

  task automatic test_stall();
    logic [3:0] pat = 4'b1001;
    bit prev_stall = 1'b0;
    logic signed [15:0] prev_data = 16'sd0;
    int stalls = 0;
    int dseen = 0;
    bit ok;
    bit fin = 1'b0;
    rx_q.delete();
    x_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 600 && !fin; c++) begin
      if (prev_stall) begin
        stalls++;
        checks++;
        if (x_valid !== 1'b1 || x_data !== prev_data) begin
          failures++;
          $display("FAIL stall_hold_c%0d: got valid=%b data=%0d, want 1 %0d", c, x_valid, x_data, prev_data);
        end
      end
      if (done) dseen++;
      if (dseen > 0 && !busy) fin = 1'b1;
      x_ready = pat[c % 4];
      #1;
      prev_stall = x_valid && !x_ready;
      prev_data = x_data;
      tick();
    end
    x_ready = 1'b1;
    ok = (rx_q.size() == 64);
    for (int k = 0; k < 64 && ok; k++) if (rx_q[k] !== 16'(k)) ok = 1'b0;
    checks++;
    if (!ok || dseen != 1 || stalls == 0) begin
      failures++;
      $display("FAIL stall_rx: got %0d beats done=%0d stalls=%0d, want ramp of 64, 1, >0",
               rx_q.size(), dseen, stalls);
    end
  endtask

  task automatic test_signs();
    bit ok;
    for (int i = 0; i < 64; i++) begin
      wr_en = 1'b1; wr_addr = 6'(i);
      wr_data = (i == 0) ? 16'h8000 : ((i == 63) ? 16'h7FFF : 16'hFFFF);
      tick();
    end
    wr_en = 1'b0;
    rx_q.delete();
    run_vector(ok);
    checks++;
    if (!ok || rx_q.size() != 64) begin
      failures++;
      $display("FAIL signs_count: got ok=%b beats=%0d, want 1 64", ok, rx_q.size());
    end else begin
      checks++;
      if (rx_q[0] !== -16'sd32768 || !(rx_q[0] < 0)) begin
        failures++;
        $display("FAIL signs_min: got %0d, want -32768", rx_q[0]);
      end
      checks++;
      if (rx_q[63] !== 16'sd32767 || !(rx_q[63] > 0)) begin
        failures++;
        $display("FAIL signs_max: got %0d, want 32767", rx_q[63]);
      end
      checks++;
      if (rx_q[1] !== -16'sd1 || rx_q[31] !== -16'sd1 || rx_q[62] !== -16'sd1) begin
        failures++;
        $display("FAIL signs_neg1: got %0d %0d %0d, want -1 -1 -1", rx_q[1], rx_q[31], rx_q[62]);
      end
    end
  endtask

  task automatic test_ignore_while_busy();
    bit ok;
    bit fin = 1'b0;
    load_ramp();
    rx_q.delete();
    x_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    repeat (10) tick();
    checks++;
    if (x_data !== 16'sd10) begin
      failures++;
      $display("FAIL ignore_beat10: got %0d, want 10", x_data);
    end
    start = 1'b1; wr_en = 1'b1; wr_addr = 6'd5; wr_data = 16'd999;
    tick();
    start = 1'b0; wr_en = 1'b0;
    for (int c = 0; c < 200 && !fin; c++) begin
      if (done) fin = 1'b1;
      tick();
    end
    checks++;
    if (!fin || busy !== 1'b0 || x_valid !== 1'b0) begin
      failures++;
      $display("FAIL ignore_no_restart: got fin=%b busy=%b valid=%b, want 1 0 0", fin, busy, x_valid);
    end
    ok = (rx_q.size() == 64);
    for (int k = 0; k < 64 && ok; k++) if (rx_q[k] !== 16'(k)) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL ignore_rx: got %0d beats, want ramp of 64", rx_q.size());
    end
    rx_q.delete();
    run_vector(ok);
    checks++;
    if (!ok || rx_q.size() != 64 || rx_q[5] !== 16'sd5) begin
      failures++;
      $display("FAIL ignore_addr5: got ok=%b beats=%0d, want 1 64 and addr5=5", ok, rx_q.size());
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    rx_q.delete();
    x_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    repeat (20) tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || x_data !== 16'sd0) begin
      failures++;
      $display("FAIL areset_immediate: got valid=%b busy=%b done=%b data=%0d, want 0 0 0 0",
               x_valid, busy, done, x_data);
    end
    tick(); tick(); tick();
    checks++;
    if (rx_q.size() != 20) begin
      failures++;
      $display("FAIL areset_beats: got %0d beats, want 20", rx_q.size());
    end
    reset = 1'b0;
    tick();
    checks++;
    if (rx_q.size() != 20 || x_valid !== 1'b0) begin
      failures++;
      $display("FAIL areset_quiet: got beats=%0d valid=%b, want 20 0", rx_q.size(), x_valid);
    end
    rx_q.delete();
    run_vector(ok);
    for (int k = 0; k < 64 && ok; k++) if (rx_q.size() != 64 || rx_q[k] !== 16'(k)) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL areset_restart: got %0d beats, want ramp of 64 from addr 0", rx_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit fin = 1'b0;
    rx_q.delete(); done_cnt = 0;
    x_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 200 && !done; c++) tick();
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle_gap: got busy=%b, want 0", busy);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (busy !== 1'b1 || x_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_restart: got busy=%b valid=%b, want 1 0", busy, x_valid);
    end
    tick();
    tick();
    checks++;
    if (x_valid !== 1'b1 || x_data !== 16'sd0) begin
      failures++;
      $display("FAIL b2b_first: got valid=%b data=%0d, want 1 0", x_valid, x_data);
    end
    for (int c = 0; c < 200 && !fin; c++) begin
      if (done) fin = 1'b1;
      tick();
    end
    ok = fin && (rx_q.size() == 128);
    for (int k = 0; k < 128 && ok; k++) if (rx_q[k] !== 16'(k % 64)) ok = 1'b0;
    checks++;
    if (!ok || done_cnt != 2) begin
      failures++;
      $display("FAIL b2b_rx: got %0d beats done_cnt=%0d, want two ramps (128) and 2", rx_q.size(), done_cnt);
    end
  endtask

  task automatic test_start_with_write();
    bit ok;
    rx_q.delete();
    x_ready = 1'b1;
    start = 1'b1; wr_en = 1'b1; wr_addr = 6'd7; wr_data = 16'd700;
    tick();
    start = 1'b0; wr_en = 1'b0;
    for (int c = 0; c < 200 && !done; c++) tick();
    tick();
    checks++;
    if (rx_q.size() != 64 || rx_q[7] !== 16'sd7) begin
      failures++;
      $display("FAIL coincide_old: got beats=%0d, want 64 with addr7=7", rx_q.size());
    end
    rx_q.delete();
    run_vector(ok);
    checks++;
    if (!ok || rx_q.size() != 64 || rx_q[7] !== 16'sd700 || rx_q[8] !== 16'sd8) begin
      failures++;
      $display("FAIL coincide_new: got beats=%0d, want 64 with addr7=700 addr8=8", rx_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_signs();
    test_ignore_while_busy();
    test_async_reset();
    test_back_to_back();
    test_start_with_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
